elevator_dispatcher: RTL and testbench
======================================

Name: elevator_dispatcher

Overview:
Hall-call scheduler for a two-car elevator bank. It collects floor hall-call buttons into a pending vector and picks one pending floor at a time, using a round-robin pointer. It offers that floor to the nearest idle car over a valid/ready handshake. It sits above the per-car elevator controllers and feeds their floor-request inputs; a timeout guards against a car that never accepts.

Parameters:
NUM_FLOORS, 16, number of floors; floor 0 is a service level and is never dispatched
FLOOR_W, 4, floor index width (clog2 NUM_FLOORS)
ASSIGN_TIMEOUT, 32, OFFER cycles without ready before the offer is withdrawn

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low (0 = reset)
cfg_top_floor  input  FLOOR_W  highest serviceable floor (from the config register)
hall_call  input  NUM_FLOORS  level-sampled hall-call buttons, bit i = floor i
car0_floor  input  FLOOR_W  current floor of car 0
car1_floor  input  FLOOR_W  current floor of car 1
car_idle  input  2  bit c = car c is stopped in WAIT with no stops outstanding
assign_ready  input  2  bit c = car c accepts the offered floor this cycle
assign_valid  output  2  one-hot (or zero) offer to car c
assign_floor  output  FLOOR_W  floor being offered; valid only when assign_valid != 0
pending_calls  output  NUM_FLOORS  registered pending hall calls
busy  output  1  FSM not in IDLE
timeout_count  output  8  saturating count of withdrawn offers

Behaviour:
- Reset (rst==0 at a posedge) puts every output and register into a known state:
  - assign_valid=0, assign_floor=0, pending_calls=0, busy=0, timeout_count=0.
  - rr_ptr=1, car_mask=0, state=IDLE.
  - Reset mid-OFFER drops the offer the same edge; nothing is remembered.
- Pending vector:
  - Bit i is set at the edge where hall_call[i]=1, 1<=i<=cfg_top_floor.
  - Bit 0 and bits above cfg_top_floor are never set. If cfg_top_floor=0, no calls are accepted.
  - On an accepted handshake, pending[assign_floor] is cleared. A same-cycle set and clear of that bit resolves to clear.
  - When cfg_top_floor is lowered, bits above the new value are cleared on the next edge. An OFFER already in progress is not affected.
- FSM states: IDLE, PICK, OFFER.
  - IDLE: if pending != 0, go to PICK and latch sel_floor. sel_floor is the first set bit searching upward from rr_ptr, wrapping from NUM_FLOORS-1 back to 1. Otherwise stay in IDLE.
  - PICK: eligible = car_idle & ~car_mask.
    - If eligible==0, stay in PICK.
    - Otherwise go to OFFER with sel_car = the eligible car with the smallest |carN_floor - sel_floor| (unsigned absolute difference). Ties go to car 0.
    - If pending[sel_floor] has been cleared meanwhile (cfg lowered), return to IDLE instead.
  - OFFER: assign_valid[sel_car]=1, assign_floor=sel_floor.
    - Both are stable until accept or timeout, independent of car_idle or cfg changes.
    - Accept (assign_ready[sel_car]=1): clear the pending bit, set rr_ptr=sel_floor+1 (wrapping to 1 past NUM_FLOORS-1), set car_mask=0, go to IDLE.
    - assign_ready on the non-offered car is ignored.
    - Timeout: after ASSIGN_TIMEOUT OFFER cycles with no accept, deassert valid, set car_mask[sel_car]=1, increment timeout_count (saturates at 255), return to PICK with the same sel_floor. The pending bit is kept.
    - If both cars become masked, clear car_mask and retry both.
- Latency: hall_call sampled at edge N gives pending at N+1, PICK at N+2, assign_valid high after N+3 when a car is idle. The minimum gap between back-to-back offers is 2 cycles (IDLE, PICK).
- The timeout counter resets on every entry to OFFER.
- A car already at sel_floor (distance 0) is a legal target and is offered normally.

Decomposition:
- Shared package elevator_pkg: dispatch state enum (IDLE/PICK/OFFER), FLOOR_W, NUM_FLOORS and car-index constants. The ELEV_MOTOR_* codes also move there for the car controllers.
- One sub-module, rr_floor_picker: combinational round-robin first-set search of pending from rr_ptr with wrap, skipping bit 0. It returns the found flag and the floor index.

Test Plan:
- Reset/idle: rst=0 for 2 cycles then 1, no calls -> all outputs 0, busy=0, no assign_valid for 20 cycles.
- Nearest car: car0_floor=2, car1_floor=9, both idle, cfg_top_floor=15, hall_call[8] pulse at N -> assign_valid=2'b10, assign_floor=8 after N+3. Ready the next cycle -> pending_calls[8]=0, state IDLE.
- Tie and round-robin: cars at 5 and 5, calls on floors 3 and 12, rr_ptr=1 -> first offer floor 3 to car 0. After accept, the next offer is floor 12 (rr_ptr=4).
- Timeout: car 0 idle and never ready, car 1 busy -> valid held 32 cycles, then dropped and timeout_count=1. When car 1 goes idle, floor re-offered to car 1.
- Config clamp: pending {4,14}, cfg_top_floor written 15->10 -> pending_calls[14] cleared next edge. hall_call[12] ignored, floor 4 still dispatched. hall_call[0] never sets a bit.
- Collision/reset: during OFFER of floor 7, hall_call[7]=1 in the accept cycle -> pending[7]=0. A separate run asserting rst=0 mid-OFFER -> assign_valid=0 next edge, pending cleared.

Source files
------------

// File: rtl/elevator_pkg.sv
// ============================================================================
// Module   : elevator_pkg
// Brief    : Shared types and constants for the elevator bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

    localparam int NUM_FLOORS = 16;
    localparam int FLOOR_W    = 4;
    localparam int NUM_CARS   = 2;

    localparam int c_CAR0 = 0;
    localparam int c_CAR1 = 1;

    localparam logic [1:0] ELEV_MOTOR_STOP = 2'd0;
    localparam logic [1:0] ELEV_MOTOR_UP   = 2'd1;
    localparam logic [1:0] ELEV_MOTOR_DOWN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PICK  = 2'd1,
        ST_OFFER = 2'd2
    } dispatch_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_floor_picker.sv
// ============================================================================
// Module   : rr_floor_picker
// Brief    : First pending floor at or above rr_ptr, wrapping to floor 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_floor_picker
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    rr_ptr,
    output logic                  found,
    output logic [FLOOR_W-1:0]    floor_idx
);

    // Floor 0 is excluded, so the search ring has NUM_FLOORS-1 entries.
    always_comb begin
        int base;
        int idx;
        found     = 1'b0;
        floor_idx = '0;
        idx       = 0;
        base      = (rr_ptr == '0) ? 0 : int'(rr_ptr) - 1;
        for (int k = 0; k < NUM_FLOORS - 1; k++) begin
            idx = ((base + k) % (NUM_FLOORS - 1)) + 1;
            if (!found && pending[idx]) begin
                found     = 1'b1;
                floor_idx = FLOOR_W'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/elevator_dispatcher.sv
// ============================================================================
// Module   : elevator_dispatcher
// Brief    : Two-car hall-call scheduler with round-robin pick and timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_dispatcher
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS     = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W        = elevator_pkg::FLOOR_W,
    parameter int ASSIGN_TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLOOR_W-1:0]    cfg_top_floor,
    input  logic [NUM_FLOORS-1:0] hall_call,
    input  logic [FLOOR_W-1:0]    car0_floor,
    input  logic [FLOOR_W-1:0]    car1_floor,
    input  logic [1:0]            car_idle,
    input  logic [1:0]            assign_ready,
    output logic [1:0]            assign_valid,
    output logic [FLOOR_W-1:0]    assign_floor,
    output logic [NUM_FLOORS-1:0] pending_calls,
    output logic                  busy,
    output logic [7:0]            timeout_count
);

    localparam int                 c_TMR_W     = $clog2(ASSIGN_TIMEOUT) + 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(ASSIGN_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [FLOOR_W-1:0] c_FLOOR_ONE = FLOOR_W'(1);
    localparam logic [FLOOR_W-1:0] c_FLOOR_MAX = FLOOR_W'(NUM_FLOORS - 1);

    dispatch_state_t       r_state, w_state_nxt;
    logic [NUM_FLOORS-1:0] r_pending, w_pending_nxt;
    logic [FLOOR_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [1:0]            r_car_mask, w_car_mask_nxt;
    logic [FLOOR_W-1:0]    r_sel_floor, w_sel_floor_nxt;
    logic                  r_sel_car, w_sel_car_nxt;
    logic [c_TMR_W-1:0]    r_timer, w_timer_nxt;
    logic [7:0]            r_timeout_count, w_timeout_count_nxt;

    logic [NUM_FLOORS-1:0] w_cfg_mask;
    logic                  w_pick_found;
    logic [FLOOR_W-1:0]    w_pick_floor;
    logic [FLOOR_W-1:0]    w_dist0, w_dist1;
    logic [1:0]            w_eligible;
    logic [1:0]            w_sel_onehot;
    logic [1:0]            w_mask_hit;
    logic                  w_accept;
    logic                  w_timeout;

    rr_floor_picker #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_picker (
        .pending   (r_pending),
        .rr_ptr    (r_rr_ptr),
        .found     (w_pick_found),
        .floor_idx (w_pick_floor)
    );

    always_comb begin
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_cfg_mask[i] = (i != 0) && (i <= int'(cfg_top_floor));
        end
    end

    assign w_dist0      = (car0_floor >= r_sel_floor) ? car0_floor - r_sel_floor
                                                      : r_sel_floor - car0_floor;
    assign w_dist1      = (car1_floor >= r_sel_floor) ? car1_floor - r_sel_floor
                                                      : r_sel_floor - car1_floor;
    assign w_eligible   = car_idle & ~r_car_mask;
    assign w_sel_onehot = r_sel_car ? 2'b10 : 2'b01;
    assign w_mask_hit   = r_car_mask | w_sel_onehot;
    assign w_accept     = (r_state == ST_OFFER) && assign_ready[r_sel_car];
    assign w_timeout    = (r_state == ST_OFFER) && !w_accept && (r_timer == c_TMR_LAST);

    // Accept clear wins over a simultaneous hall-call set of the same floor.
    always_comb begin
        w_pending_nxt = (r_pending | hall_call) & w_cfg_mask;
        if (w_accept) begin
            w_pending_nxt[r_sel_floor] = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_rr_ptr_nxt        = r_rr_ptr;
        w_car_mask_nxt      = r_car_mask;
        w_sel_floor_nxt     = r_sel_floor;
        w_sel_car_nxt       = r_sel_car;
        w_timer_nxt         = r_timer;
        w_timeout_count_nxt = r_timeout_count;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt     = ST_PICK;
                    w_sel_floor_nxt = w_pick_floor;
                end
            end
            ST_PICK: begin
                if (!r_pending[r_sel_floor]) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_eligible != 2'b00) begin
                    w_state_nxt   = ST_OFFER;
                    w_timer_nxt   = '0;
                    w_sel_car_nxt = (w_eligible == 2'b10) ||
                                    ((w_eligible == 2'b11) && (w_dist1 < w_dist0));
                end
            end
            ST_OFFER: begin
                if (w_accept) begin
                    w_state_nxt    = ST_IDLE;
                    w_car_mask_nxt = 2'b00;
                    w_rr_ptr_nxt   = (r_sel_floor == c_FLOOR_MAX) ? c_FLOOR_ONE
                                                                  : r_sel_floor + c_FLOOR_ONE;
                end else if (w_timeout) begin
                    w_state_nxt    = ST_PICK;
                    // Once both cars have refused, give both another chance.
                    w_car_mask_nxt = (w_mask_hit == 2'b11) ? 2'b00 : w_mask_hit;
                    if (r_timeout_count != 8'hFF) begin
                        w_timeout_count_nxt = r_timeout_count + 8'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer + c_TMR_ONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= ST_IDLE;
            r_pending       <= '0;
            r_rr_ptr        <= c_FLOOR_ONE;
            r_car_mask      <= 2'b00;
            r_sel_floor     <= '0;
            r_sel_car       <= 1'b0;
            r_timer         <= '0;
            r_timeout_count <= 8'd0;
        end else begin
            r_state         <= w_state_nxt;
            r_pending       <= w_pending_nxt;
            r_rr_ptr        <= w_rr_ptr_nxt;
            r_car_mask      <= w_car_mask_nxt;
            r_sel_floor     <= w_sel_floor_nxt;
            r_sel_car       <= w_sel_car_nxt;
            r_timer         <= w_timer_nxt;
            r_timeout_count <= w_timeout_count_nxt;
        end
    end

    assign assign_valid  = (r_state == ST_OFFER) ? w_sel_onehot : 2'b00;
    assign assign_floor  = (r_state == ST_OFFER) ? r_sel_floor : '0;
    assign pending_calls = r_pending;
    assign busy          = (r_state != ST_IDLE);
    assign timeout_count = r_timeout_count;

endmodule

`default_nettype wire

// File: tb/tb_elevator_dispatcher.sv
// ============================================================================
// Module   : tb_elevator_dispatcher
// Brief    : Directed self-checking bench for elevator_dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elevator_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cfg_top_floor;
    logic [15:0] hall_call;
    logic [3:0]  car0_floor;
    logic [3:0]  car1_floor;
    logic [1:0]  car_idle;
    logic [1:0]  assign_ready;
    logic [1:0]  assign_valid;
    logic [3:0]  assign_floor;
    logic [15:0] pending_calls;
    logic        busy;
    logic [7:0]  timeout_count;

    int n_checks = 0;
    int n_errors = 0;

    elevator_dispatcher #(
        .NUM_FLOORS     (16),
        .FLOOR_W        (4),
        .ASSIGN_TIMEOUT (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_top_floor (cfg_top_floor),
        .hall_call     (hall_call),
        .car0_floor    (car0_floor),
        .car1_floor    (car1_floor),
        .car_idle      (car_idle),
        .assign_ready  (assign_ready),
        .assign_valid  (assign_valid),
        .assign_floor  (assign_floor),
        .pending_calls (pending_calls),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        hall_call    = '0;
        assign_ready = 2'b00;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        cfg_top_floor = 4'd15;
        car0_floor    = 4'd0;
        car1_floor    = 4'd0;
        car_idle      = 2'b00;
        do_reset();
        n_checks++;
        if (assign_valid !== 2'b00) begin n_errors++; $display("FAIL reset_valid: got %b expected 00", assign_valid); end
        n_checks++;
        if (assign_floor !== 4'd0) begin n_errors++; $display("FAIL reset_floor: got %0d expected 0", assign_floor); end
        n_checks++;
        if (pending_calls !== 16'h0000) begin n_errors++; $display("FAIL reset_pending: got %h expected 0000", pending_calls); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (timeout_count !== 8'd0) begin n_errors++; $display("FAIL reset_tmo: got %0d expected 0", timeout_count); end
        car_idle = 2'b11;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (assign_valid !== 2'b00 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL idle_quiet: cycle %0d valid %b busy %b expected 00/0", i, assign_valid, busy);
            end
        end
    endtask

    task automatic test_nearest();
        cfg_top_floor = 4'd15;
        car0_floor    = 4'd2;
        car1_floor    = 4'd9;
        car_idle      = 2'b11;
        hall_call     = 16'h0100;
        tick();
        hall_call = '0;
        n_checks++;
        if (pending_calls !== 16'h0100) begin n_errors++; $display("FAIL near_pending_set: got %h expected 0100", pending_calls); end
        tick();
        n_checks++;
        if (busy !== 1'b1 || assign_valid !== 2'b00) begin n_errors++; $display("FAIL near_pick: busy %b valid %b expected 1/00", busy, assign_valid); end
        tick();
        n_checks++;
        if (assign_valid !== 2'b10) begin n_errors++; $display("FAIL near_valid: got %b expected 10", assign_valid); end
        n_checks++;
        if (assign_floor !== 4'd8) begin n_errors++; $display("FAIL near_floor: got %0d expected 8", assign_floor); end
        assign_ready = 2'b10;
        tick();
        assign_ready = 2'b00;
        n_checks++;
        if (pending_calls !== 16'h0000) begin n_errors++; $display("FAIL near_clear: got %h expected 0000", pending_calls); end
        n_checks++;
        if (busy !== 1'b0 || assign_valid !== 2'b00) begin n_errors++; $display("FAIL near_idle: busy %b valid %b expected 0/00", busy, assign_valid); end
    endtask

    task automatic test_tie_rr();
        do_reset();
        car0_floor = 4'd5;
        car1_floor = 4'd5;
        car_idle   = 2'b11;
        hall_call  = 16'h1008;
        tick();
        hall_call = '0;
        tick();
        tick();
        n_checks++;
        if (assign_valid !== 2'b01 || assign_floor !== 4'd3) begin n_errors++; $display("FAIL tie_first: valid %b floor %0d expected 01/3", assign_valid, assign_floor); end
        assign_ready = 2'b01;
        tick();
        assign_ready = 2'b00;
        n_checks++;
        if (pending_calls !== 16'h1000) begin n_errors++; $display("FAIL tie_pending: got %h expected 1000", pending_calls); end
        tick();
        n_checks++;
        if (assign_valid !== 2'b00 || busy !== 1'b1) begin n_errors++; $display("FAIL rr_gap: valid %b busy %b expected 00/1", assign_valid, busy); end
        tick();
        n_checks++;
        if (assign_valid !== 2'b01 || assign_floor !== 4'd12) begin n_errors++; $display("FAIL rr_second: valid %b floor %0d expected 01/12", assign_valid, assign_floor); end
        assign_ready = 2'b10;
        tick();
        n_checks++;
        if (assign_valid !== 2'b01 || pending_calls !== 16'h1000) begin n_errors++; $display("FAIL wrong_ready: valid %b pending %h expected 01/1000", assign_valid, pending_calls); end
        assign_ready = 2'b01;
        tick();
        assign_ready = 2'b00;
        n_checks++;
        if (pending_calls !== 16'h0000 || busy !== 1'b0) begin n_errors++; $display("FAIL rr_done: pending %h busy %b expected 0000/0", pending_calls, busy); end
    endtask

    task automatic test_timeout();
        do_reset();
        car0_floor = 4'd3;
        car1_floor = 4'd10;
        car_idle   = 2'b01;
        hall_call  = 16'h0040;
        tick();
        hall_call = '0;
        tick();
        tick();
        n_checks++;
        if (assign_valid !== 2'b01 || assign_floor !== 4'd6) begin n_errors++; $display("FAIL tmo_offer: valid %b floor %0d expected 01/6", assign_valid, assign_floor); end
        for (int i = 2; i <= 32; i++) begin
            tick();
            n_checks++;
            if (assign_valid !== 2'b01) begin n_errors++; $display("FAIL tmo_hold: cycle %0d valid %b expected 01", i, assign_valid); end
        end
        tick();
        n_checks++;
        if (assign_valid !== 2'b00) begin n_errors++; $display("FAIL tmo_drop: got %b expected 00", assign_valid); end
        n_checks++;
        if (timeout_count !== 8'd1) begin n_errors++; $display("FAIL tmo_count: got %0d expected 1", timeout_count); end
        n_checks++;
        if (busy !== 1'b1 || pending_calls !== 16'h0040) begin n_errors++; $display("FAIL tmo_keep: busy %b pending %h expected 1/0040", busy, pending_calls); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (assign_valid !== 2'b00) begin n_errors++; $display("FAIL tmo_masked: cycle %0d valid %b expected 00", i, assign_valid); end
        end
        car_idle = 2'b11;
        tick();
        n_checks++;
        if (assign_valid !== 2'b10 || assign_floor !== 4'd6) begin n_errors++; $display("FAIL tmo_reoffer: valid %b floor %0d expected 10/6", assign_valid, assign_floor); end
        assign_ready = 2'b10;
        tick();
        assign_ready = 2'b00;
        n_checks++;
        if (pending_calls !== 16'h0000 || timeout_count !== 8'd1) begin n_errors++; $display("FAIL tmo_accept: pending %h count %0d expected 0000/1", pending_calls, timeout_count); end
    endtask

    task automatic test_clamp();
        do_reset();
        cfg_top_floor = 4'd15;
        car_idle      = 2'b00;
        hall_call     = 16'h4010;
        tick();
        n_checks++;
        if (pending_calls !== 16'h4010) begin n_errors++; $display("FAIL clamp_set: got %h expected 4010", pending_calls); end
        hall_call     = '0;
        cfg_top_floor = 4'd10;
        tick();
        n_checks++;
        if (pending_calls !== 16'h0010) begin n_errors++; $display("FAIL clamp_drop: got %h expected 0010", pending_calls); end
        hall_call = 16'h1001;
        tick();
        hall_call = '0;
        n_checks++;
        if (pending_calls !== 16'h0010) begin n_errors++; $display("FAIL clamp_ignore: got %h expected 0010", pending_calls); end
        car0_floor = 4'd0;
        car1_floor = 4'd0;
        car_idle   = 2'b01;
        tick();
        n_checks++;
        if (assign_valid !== 2'b01 || assign_floor !== 4'd4) begin n_errors++; $display("FAIL clamp_offer: valid %b floor %0d expected 01/4", assign_valid, assign_floor); end
        assign_ready = 2'b01;
        tick();
        assign_ready = 2'b00;
        n_checks++;
        if (pending_calls !== 16'h0000) begin n_errors++; $display("FAIL clamp_accept: got %h expected 0000", pending_calls); end
        cfg_top_floor = 4'd0;
        hall_call     = 16'h0008;
        tick();
        hall_call = '0;
        n_checks++;
        if (pending_calls !== 16'h0000) begin n_errors++; $display("FAIL cfg_zero: got %h expected 0000", pending_calls); end
        cfg_top_floor = 4'd15;
    endtask

    task automatic test_collision();
        do_reset();
        car0_floor = 4'd7;
        car1_floor = 4'd1;
        car_idle   = 2'b11;
        hall_call  = 16'h0080;
        tick();
        hall_call = '0;
        tick();
        tick();
        n_checks++;
        if (assign_valid !== 2'b01 || assign_floor !== 4'd7) begin n_errors++; $display("FAIL coll_offer: valid %b floor %0d expected 01/7", assign_valid, assign_floor); end
        assign_ready = 2'b01;
        hall_call    = 16'h0080;
        tick();
        assign_ready = 2'b00;
        hall_call    = '0;
        n_checks++;
        if (pending_calls !== 16'h0000 || busy !== 1'b0) begin n_errors++; $display("FAIL coll_clear: pending %h busy %b expected 0000/0", pending_calls, busy); end
    endtask

    task automatic test_reset_mid_offer();
        hall_call = 16'h1020;
        tick();
        hall_call = '0;
        tick();
        tick();
        n_checks++;
        if (assign_valid !== 2'b01 || assign_floor !== 4'd12) begin n_errors++; $display("FAIL mid_offer: valid %b floor %0d expected 01/12", assign_valid, assign_floor); end
        rst = 1'b0;
        tick();
        n_checks++;
        if (assign_valid !== 2'b00 || assign_floor !== 4'd0) begin n_errors++; $display("FAIL mid_drop: valid %b floor %0d expected 00/0", assign_valid, assign_floor); end
        n_checks++;
        if (pending_calls !== 16'h0000 || busy !== 1'b0) begin n_errors++; $display("FAIL mid_state: pending %h busy %b expected 0000/0", pending_calls, busy); end
        rst = 1'b1;
        tick();
        n_checks++;
        if (pending_calls !== 16'h0000 || assign_valid !== 2'b00) begin n_errors++; $display("FAIL mid_after: pending %h valid %b expected 0000/00", pending_calls, assign_valid); end
    endtask

    initial begin
        rst           = 1'b0;
        cfg_top_floor = 4'd15;
        hall_call     = '0;
        car0_floor    = 4'd0;
        car1_floor    = 4'd0;
        car_idle      = 2'b00;
        assign_ready  = 2'b00;
        test_reset();
        test_nearest();
        test_tie_rr();
        test_timeout();
        test_clamp();
        test_collision();
        test_reset_mid_offer();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
